// File: rtl/frame_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// frame_buffer_ctrl
//   Double-buffered framebuffer controller sitting behind the alpha blender.
//   Shares one synchronous 24-bit SRAM port between blender read-modify-write
//   traffic (back buffer) and display scan-out reads (front buffer). The two
//   buffers swap on the first display vsync after the blender reports a
//   finished frame.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   pixel_number, read, write  blender request; held until blend_ack
//   write_r/g/b                blender write data
//   frame_done                 blender finished drawing the back buffer
//   blend_ack                  blender request accepted this cycle (comb.)
//   read_valid, read_r/g/b     blender read return (registered, 1-cycle pulse)
//   disp_req, disp_addr        display read request (always accepted)
//   disp_vsync                 display vertical sync
//   disp_valid, disp_r/g/b     display read return (registered, 1-cycle pulse)
//   front_sel                  buffer currently scanned out
//   frame_swapped              1-cycle pulse when the buffers swap
//   mem_addr/we/re/wdata       SRAM command, registered, {buffer, pixel}
//   mem_rdata                  SRAM read data
//
// Read timing: a read accepted in cycle N drives mem_re in N+1. mem_rdata is
// captured MEM_LAT cycles after acceptance (cycle N+MEM_LAT) and the result
// register presents it with its valid pulse in cycle N+MEM_LAT+1. A tag
// pipeline of MEM_LAT stages plus the output stage tracks which reads are in
// flight, who issued them and whether they were out of range.
// -----------------------------------------------------------------------------
module frame_buffer_ctrl #(
  parameter int ADDR_W    = 19,
  parameter int PIX_COUNT = 307200,
  parameter int MEM_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pixel_number,
  input  logic              read,
  input  logic              write,
  input  logic [7:0]        write_r,
  input  logic [7:0]        write_g,
  input  logic [7:0]        write_b,
  input  logic              frame_done,
  output logic              blend_ack,
  output logic              read_valid,
  output logic [7:0]        read_r,
  output logic [7:0]        read_g,
  output logic [7:0]        read_b,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_vsync,
  output logic              disp_valid,
  output logic [7:0]        disp_r,
  output logic [7:0]        disp_g,
  output logic [7:0]        disp_b,
  output logic              front_sel,
  output logic              frame_swapped,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata
);

  // Compare one bit wider so PIX_COUNT == 2**ADDR_W still works.
  localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W + 1)'(PIX_COUNT);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } swap_state_e;

  typedef struct packed {
    logic valid;
    logic disp;   // 1: display read, 0: blender read
    logic oor;    // out of range: return zero, SRAM was not accessed
  } tag_t;

  swap_state_e state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic        swapped_q, swap_now;
  logic        swap_pending;

  logic              disp_in_range, blend_in_range;
  logic              ack;
  tag_t              tag_in;
  tag_t [MEM_LAT-1:0] tag_q;
  tag_t              tag_ret;

  logic [ADDR_W:0] mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_re_q, mem_re_d;
  logic [23:0]     mem_wdata_q, mem_wdata_d;

  logic        read_valid_q, disp_valid_q;
  logic [23:0] read_rgb_q, disp_rgb_q;

  // ---------------------------------------------------------------------------
  // Swap FSM
  // ---------------------------------------------------------------------------
  assign swap_pending = (state_q == S_PENDING);

  always_comb begin
    state_d  = state_q;
    swap_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          // Frame finished exactly on vsync: swap right away.
          if (disp_vsync) swap_now = 1'b1;
          else            state_d  = S_PENDING;
        end
      end
      S_PENDING: begin
        if (disp_vsync) begin
          swap_now = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign front_sel_d = front_sel_q ^ swap_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      front_sel_q <= 1'b0;
      swapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swapped_q   <= swap_now;
    end
  end

  // ---------------------------------------------------------------------------
  // Request arbitration and SRAM command
  // ---------------------------------------------------------------------------
  assign disp_in_range  = ({1'b0, disp_addr}    < PIX_LIM);
  assign blend_in_range = ({1'b0, pixel_number} < PIX_LIM);
  assign ack            = (read | write) & ~disp_req & ~swap_pending;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    tag_in      = '0;
    if (disp_req) begin
      tag_in.valid = 1'b1;
      tag_in.disp  = 1'b1;
      tag_in.oor   = ~disp_in_range;
      if (disp_in_range) begin
        mem_re_d   = 1'b1;
        mem_addr_d = {front_sel_q, disp_addr};
      end
    end else if (ack) begin
      if (write) begin
        // Write wins when read and write are both raised.
        if (blend_in_range) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {~front_sel_q, pixel_number};
          mem_wdata_d = {write_r, write_g, write_b};
        end
      end else begin
        tag_in.valid = 1'b1;
        tag_in.disp  = 1'b0;
        tag_in.oor   = ~blend_in_range;
        if (blend_in_range) begin
          mem_re_d   = 1'b1;
          mem_addr_d = {~front_sel_q, pixel_number};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight read tracking and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_ret = tag_q[MEM_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_valid_q <= 1'b0;
      disp_valid_q <= 1'b0;
      read_rgb_q   <= '0;
      disp_rgb_q   <= '0;
    end else begin
      read_valid_q <= tag_ret.valid & ~tag_ret.disp;
      disp_valid_q <= tag_ret.valid &  tag_ret.disp;
      if (tag_ret.valid & ~tag_ret.disp) begin
        read_rgb_q <= tag_ret.oor ? 24'h0 : mem_rdata;
      end
      if (tag_ret.valid & tag_ret.disp) begin
        disp_rgb_q <= tag_ret.oor ? 24'h0 : mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign blend_ack     = ack;
  assign read_valid    = read_valid_q;
  assign read_r        = read_rgb_q[23:16];
  assign read_g        = read_rgb_q[15:8];
  assign read_b        = read_rgb_q[7:0];
  assign disp_valid    = disp_valid_q;
  assign disp_r        = disp_rgb_q[23:16];
  assign disp_g        = disp_rgb_q[15:8];
  assign disp_b        = disp_rgb_q[7:0];
  assign front_sel     = front_sel_q;
  assign frame_swapped = swapped_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_re        = mem_re_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
module tb_frame_buffer_ctrl;

  localparam int ADDR_W    = 19;
  localparam int PIX_COUNT = 307200;
  localparam int MEM_LAT   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pixel_number;
  logic              read, write;
  logic [7:0]        write_r, write_g, write_b;
  logic              frame_done;
  logic              blend_ack;
  logic              read_valid;
  logic [7:0]        read_r, read_g, read_b;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_vsync;
  logic              disp_valid;
  logic [7:0]        disp_r, disp_g, disp_b;
  logic              front_sel;
  logic              frame_swapped;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we, mem_re;
  logic [23:0]       mem_wdata;
  logic [23:0]       mem_rdata;

  frame_buffer_ctrl #(
    .ADDR_W(ADDR_W), .PIX_COUNT(PIX_COUNT), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .pixel_number(pixel_number), .read(read), .write(write),
    .write_r(write_r), .write_g(write_g), .write_b(write_b),
    .frame_done(frame_done), .blend_ack(blend_ack),
    .read_valid(read_valid), .read_r(read_r), .read_g(read_g), .read_b(read_b),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_vsync(disp_vsync),
    .disp_valid(disp_valid), .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
    .front_sel(front_sel), .frame_swapped(frame_swapped),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM environment model: read data appears MEM_LAT (=2) cycles after the
  // controller accepts the request, i.e. one registered stage after mem_re.
  logic [23:0] sram [int];
  logic [23:0] sram_q = 24'h0;
  always @(posedge clk) begin
    if (mem_we) sram[int'(mem_addr)] = mem_wdata;
    if (mem_re) sram_q <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 24'h0;
  end
  assign mem_rdata = sram_q;

  // ---------------------------------------------------------------------------
  // Reference model: two framebuffers, the shown buffer, a pending-swap flag.
  // ---------------------------------------------------------------------------
  logic [23:0] fb [int];
  logic        m_front, m_pending, last_ack;
  logic        exp_we, exp_re, exp_swapped;
  logic [19:0] exp_addr;
  logic [23:0] exp_wdata;

  typedef struct { logic [23:0] data; int due; } exp_t;
  exp_t blend_q[$];
  exp_t disp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int fb_key(input logic b, input logic [ADDR_W-1:0] p);
    return int'(p) + (b ? PIX_COUNT : 0);
  endfunction

  function automatic logic [23:0] fb_read(input logic b, input logic [ADDR_W-1:0] p);
    if (int'(p) >= PIX_COUNT) return 24'h0;
    if (fb.exists(fb_key(b, p))) return fb[fb_key(b, p)];
    return 24'h0;
  endfunction

  // One clock cycle: check what the DUT did for last cycle's decision, then
  // apply the model to the inputs currently driven.
  task automatic cycle();
    logic ack_e;
    @(negedge clk);
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("mem_re", 32'(mem_re), 32'(exp_re));
    if (exp_we || exp_re) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    chk("front_sel", 32'(front_sel), 32'(m_front));
    chk("frame_swapped", 32'(frame_swapped), 32'(exp_swapped));

    ack_e = (read || write) && !disp_req && !m_pending;
    chk("blend_ack", 32'(blend_ack), 32'(ack_e));
    last_ack    = ack_e;
    exp_we      = 1'b0;
    exp_re      = 1'b0;
    exp_swapped = 1'b0;
    if (disp_req) begin
      if (int'(disp_addr) < PIX_COUNT) begin
        exp_re   = 1'b1;
        exp_addr = {m_front, disp_addr};
      end
      disp_q.push_back('{fb_read(m_front, disp_addr), cyc + MEM_LAT + 1});
    end else if (ack_e) begin
      if (write) begin
        if (int'(pixel_number) < PIX_COUNT) begin
          exp_we    = 1'b1;
          exp_addr  = {~m_front, pixel_number};
          exp_wdata = {write_r, write_g, write_b};
          fb[fb_key(~m_front, pixel_number)] = {write_r, write_g, write_b};
        end
      end else begin
        if (int'(pixel_number) < PIX_COUNT) begin
          exp_re   = 1'b1;
          exp_addr = {~m_front, pixel_number};
        end
        blend_q.push_back('{fb_read(~m_front, pixel_number), cyc + MEM_LAT + 1});
      end
    end
    if (disp_vsync && (m_pending || frame_done)) begin
      m_front     = ~m_front;
      m_pending   = 1'b0;
      exp_swapped = 1'b1;
    end else if (frame_done) begin
      m_pending = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read = 0; write = 0; disp_req = 0; frame_done = 0; disp_vsync = 0;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    reset = 1'b0;
    blend_q.delete();
    disp_q.delete();
    m_front = 0; m_pending = 0; last_ack = 0;
    exp_we = 0; exp_re = 0; exp_swapped = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_ctrl", 32'({read_valid, disp_valid, front_sel, frame_swapped, mem_we, mem_re}), 32'h0);
      chk("rst_read_rgb", 32'({read_r, read_g, read_b}), 32'h0);
      chk("rst_disp_rgb", 32'({disp_r, disp_g, disp_b}), 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops expected read returns whenever the DUT presents one.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (read_valid) begin
        if (blend_q.size() == 0) chk("blend_rd_unexpected", 32'(read_valid), 32'h0);
        else begin
          e = blend_q.pop_front();
          chk("blend_rd_data", 32'({read_r, read_g, read_b}), 32'(e.data));
          chk("blend_rd_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (blend_q.size() > 0 && blend_q[0].due < cyc) begin
        e = blend_q.pop_front();
        chk("blend_rd_missing", 32'(cyc), 32'(e.due));
      end
      if (disp_valid) begin
        if (disp_q.size() == 0) chk("disp_rd_unexpected", 32'(disp_valid), 32'h0);
        else begin
          e = disp_q.pop_front();
          chk("disp_rd_data", 32'({disp_r, disp_g, disp_b}), 32'(e.data));
          chk("disp_rd_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (disp_q.size() > 0 && disp_q[0].due < cyc) begin
        e = disp_q.pop_front();
        chk("disp_rd_missing", 32'(cyc), 32'(e.due));
      end
    end
  end

  function automatic logic [ADDR_W-1:0] pick_pix();
    logic [ADDR_W-1:0] edge_pix [5];
    edge_pix[0] = 19'd307198; edge_pix[1] = 19'd307199; edge_pix[2] = 19'd307200;
    edge_pix[3] = 19'd307201; edge_pix[4] = 19'h7FFFF;
    if ($urandom_range(0, 9) < 8) return ADDR_W'($urandom_range(0, 15));
    return edge_pix[$urandom_range(0, 4)];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    pixel_number = '0; disp_addr = '0;
    write_r = 0; write_g = 0; write_b = 0;
    idle_inputs();
    reset = 1'b0;
    #1;
    do_reset(3);

    // Write then read back pixel 5 in the back buffer.
    write = 1; pixel_number = 19'd5; write_r = 8'h09; write_g = 8'h06; write_b = 8'h0F;
    cycle();
    write = 0; read = 1;
    cycle();
    read = 0;
    repeat (4) cycle();

    // Display request and blender write collide: display wins.
    disp_req = 1; disp_addr = 19'd7;
    write = 1; pixel_number = 19'd9; write_r = 8'hA1; write_g = 8'hB2; write_b = 8'hC3;
    cycle();
    disp_req = 0;
    cycle();
    write = 0;
    repeat (4) cycle();

    // frame_done, vsync ten cycles later; blender write held through the stall.
    frame_done = 1;
    cycle();
    frame_done = 0;
    write = 1; pixel_number = 19'd3; write_r = 8'h33; write_g = 8'h44; write_b = 8'h55;
    repeat (9) cycle();
    disp_vsync = 1;
    cycle();
    disp_vsync = 0;
    cycle();
    write = 0;
    disp_req = 1; disp_addr = 19'd5;
    cycle();
    disp_req = 0;
    repeat (4) cycle();

    // Out-of-range pixel: accepted, no strobe, reads back zero.
    write = 1; pixel_number = 19'd307200; write_r = 8'hFF; write_g = 8'hEE; write_b = 8'hDD;
    cycle();
    write = 0; read = 1;
    cycle();
    read = 0; disp_req = 1; disp_addr = 19'd307200;
    cycle();
    disp_req = 0;
    repeat (4) cycle();

    // Reset one cycle after a read is accepted: no return may appear.
    read = 1; pixel_number = 19'd5;
    cycle();
    read = 0;
    do_reset(2);
    repeat (5) cycle();

    // Fill pixels 0..2 of the back buffer, swap on a coincident
    // frame_done/vsync, then stream three display reads.
    for (int p = 0; p < 3; p++) begin
      write = 1; pixel_number = ADDR_W'(p);
      write_r = 8'(8'h10 + p); write_g = 8'(8'h20 + p); write_b = 8'(8'h30 + p);
      cycle();
    end
    write = 0;
    frame_done = 1; disp_vsync = 1;
    cycle();
    frame_done = 0; disp_vsync = 0;
    for (int p = 0; p < 3; p++) begin
      disp_req = 1; disp_addr = ADDR_W'(p);
      cycle();
    end
    disp_req = 0;
    repeat (5) cycle();

    // Randomized traffic; blender requests are held until accepted.
    last_ack = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(read || write) || last_ack) begin
        case ($urandom_range(0, 3))
          0: begin read = 0; write = 0; end
          1: begin read = 1; write = 0; end
          2: begin read = 0; write = 1; end
          default: begin read = 1; write = 1; end
        endcase
        pixel_number = pick_pix();
        {write_r, write_g, write_b} = 24'($urandom);
      end
      disp_req   = ($urandom_range(0, 9) < 3);
      disp_addr  = pick_pix();
      frame_done = ($urandom_range(0, 49) == 0);
      disp_vsync = ($urandom_range(0, 29) == 0);
      cycle();
    end
    idle_inputs();
    repeat (8) cycle();
    chk("blend_q_drained", 32'(blend_q.size()), 32'h0);
    chk("disp_q_drained", 32'(disp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
